pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 58 +++++
 tb/tb_pc_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute program-counter sequencer with saturating wrap counter
module pc_sequencer #(
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              jump,
  input  logic [1:0]        jump_addr,
  input  logic [1:0]        inc_sum,
  input  logic              inc_stat,
  output logic [1:0]        pc,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic              exec_en,
  output logic              halted,
  output logic [WRAP_W-1:0] wrap_cnt
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t state;
  // State, pc and wrap count advance together; status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      wrap_cnt    <= '0;
      fetch_valid <= 1'b0;
      exec_en     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= FETCH;
          fetch_valid <= 1'b1;
        end
        FETCH: if (fetch_valid && fetch_ready) begin
          state       <= EXEC;
          fetch_valid <= 1'b0;
          exec_en     <= 1'b1;
        end
        EXEC: begin
          exec_en <= 1'b0;
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state       <= FETCH;
            fetch_valid <= 1'b1;
            pc          <= jump ? jump_addr : inc_sum;
            if (!jump && inc_stat && wrap_cnt != '1) wrap_cnt <= wrap_cnt + 1'b1;
          end
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table, directed and random checks of pc_sequencer against a reference model
module tb_pc_sequencer;
  localparam int W = 2;
  logic clk = 0, reset = 0, start = 0, halt_req = 0, jump = 0, fetch_ready = 0, inc_stat;
  logic [1:0] jump_addr = 0, inc_sum, pc;
  logic fetch_valid, exec_en, halted;
  logic [W-1:0] wrap_cnt;
  int vectors = 0, miscompares = 0;
  logic [1:0] m_pc, m_w;
  logic m_fv, m_ex, m_h;

  typedef struct {
    logic r, s, h, j;
    logic [1:0] ja;
    logic fr;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  assign inc_sum  = pc + 2'd1;
  assign inc_stat = (pc == 2'd3);

  pc_sequencer #(.WRAP_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .jump(jump),
    .jump_addr(jump_addr), .inc_sum(inc_sum), .inc_stat(inc_stat), .pc(pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .exec_en(exec_en),
    .halted(halted), .wrap_cnt(wrap_cnt)
  );

  function automatic logic [6:0] pk(logic [1:0] p, logic fv, logic ex, logic h, logic [1:0] w);
    return {p, fv, ex, h, w};
  endfunction

  function automatic logic [6:0] got();
    return {pc, fetch_valid, exec_en, halted, wrap_cnt};
  endfunction

  task automatic cmp(string name, logic [6:0] exp);
    vectors++;
    if (got() !== exp) begin
      miscompares++;
      $display("FAIL %s: got {pc,fv,ex,halt,wrap}=%b want %b at %0t", name, got(), exp, $time);
    end
  endtask

  task automatic apply(logic r, logic s, logic h, logic j, logic [1:0] ja, logic fr);
    reset = r; start = s; halt_req = h; jump = j; jump_addr = ja; fetch_ready = fr;
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_w = 0; m_fv = 0; m_ex = 0; m_h = 0;
    end else if (m_h) begin
    end else if (m_ex) begin
      m_ex = 0;
      if (h) m_h = 1;
      else begin
        if (j) m_pc = ja;
        else begin
          if (m_pc == 3 && m_w != 3) m_w = m_w + 1;
          m_pc = 2'((int'(m_pc) + 1) % 4);
        end
        m_fv = 1;
      end
    end else if (m_fv) begin
      if (fr) begin m_fv = 0; m_ex = 1; end
    end else if (s) m_fv = 1;
    @(negedge clk);
    cmp("model", pk(m_pc, m_fv, m_ex, m_h, m_w));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) apply(0, 1, 0, 0, 0, 1);
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0)};
    tbl[1] = '{0, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0)};
    for (int i = 2; i < 12; i++)
      tbl[i] = '{0, 1, 0, 0, 0, 1, pk(2'((i - 2) / 2), (i % 2) == 0, (i % 2) == 1, 0, 0)};
    tbl[10].exp = pk(0, 1, 0, 0, 1);
    tbl[11].exp = pk(0, 0, 1, 0, 1);
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].j, tbl[i].ja, tbl[i].fr);
      cmp($sformatf("table%0d", i), tbl[i].exp);
    end

    apply(1, 0, 0, 0, 0, 0);
    run(5);
    cmp("bp_enter", pk(2, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 1, 3, 0);
      cmp("bp_stall", pk(2, 1, 0, 0, 0));
    end
    apply(0, 0, 0, 0, 0, 1);
    cmp("bp_exec", pk(2, 0, 1, 0, 0));
    apply(0, 0, 0, 0, 0, 1);
    cmp("bp_pc3", pk(3, 1, 0, 0, 0));

    apply(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 1, 1, 1);
    cmp("jump_wrap", pk(1, 1, 0, 0, 0));
    run(2);
    cmp("jump_next", pk(2, 1, 0, 0, 0));

    run(1);
    apply(0, 0, 0, 1, 1, 1);
    run(1);
    cmp("pre_halt", pk(1, 0, 1, 0, 0));
    apply(0, 0, 1, 1, 3, 1);
    cmp("halt", pk(1, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 1, 1, 3, 1);
      cmp("halt_frozen", pk(1, 0, 0, 1, 0));
    end

    apply(1, 0, 0, 0, 0, 0);
    run(1);
    for (int k = 1; k <= 5; k++) begin
      run(8);
      cmp($sformatf("sat%0d", k), pk(0, 1, 0, 0, 2'(k > 3 ? 3 : k)));
    end

    apply(1, 0, 0, 0, 0, 0);
    run(21);
    cmp("mid_pre", pk(2, 1, 0, 0, 2));
    apply(1, 1, 0, 0, 0, 1);
    cmp("mid_reset", pk(0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 1);
      cmp("idle_hold", pk(0, 0, 0, 0, 0));
    end

    for (int i = 0; i < 3000; i++)
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 2) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
